stacker_state_tx: RTL and testbench



---
 rtl/stacker_state_tx_if.sv | 23 ++
 rtl/stacker_state_tx.sv | 193 +++++++++++++++++++
 tb/tb_stacker_state_tx.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stacker_state_tx_if.sv
// Snapshot request, game-state inputs and UART status/line outputs of the
// Stacker state transmitter.
interface stacker_state_tx_if;
    logic        send_i;
    logic [1:0]  state_i;
    logic [3:0]  block_pos_i;
    logic [1:0]  block_width_i;
    logic [3:0]  block_height_i;
    logic [89:0] board_i;
    logic        busy_o;
    logic        done_o;
    logic        tx_o;

    modport master (
        output send_i, state_i, block_pos_i, block_width_i, block_height_i, board_i,
        input  busy_o, done_o, tx_o
    );

    modport slave (
        input  send_i, state_i, block_pos_i, block_width_i, block_height_i, board_i,
        output busy_o, done_o, tx_o
    );
endinterface

// File: rtl/stacker_state_tx.sv
// Snapshots one Stacker player's state and sends it as a 16-byte UART frame.
// Build option: define STACKER_TX_PARITY_EN to add an even-parity bit per character.
module stacker_state_tx #(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              arst_i,
    stacker_state_tx_if.slave bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef STACKER_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        NEXT,
        DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [BAUD_W-1:0]   baud_reg, baud_next;
    logic [2:0]          bit_reg, bit_next;
    logic [3:0]          byte_reg, byte_next;
    logic [7:0]          shift_reg, shift_next;
    logic [7:0]          csum_reg, csum_next;
    logic [111:0]        payload_reg, payload_next;
    logic                tx_reg, tx_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
`ifdef STACKER_TX_PARITY_EN
    logic                parity_reg, parity_next;
`endif

    logic bit_end;
    logic stop_end;

    assign bit_end  = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));
    // The stop bit's final cycle is spent in NEXT, so STOP itself ends one cycle early.
    assign stop_end = (baud_reg == BAUD_W'(CLKS_PER_BIT - 2));

    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_reg     <= '0;
            byte_reg    <= '0;
            shift_reg   <= '0;
            csum_reg    <= '0;
            payload_reg <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef STACKER_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_reg     <= bit_next;
            byte_reg    <= byte_next;
            shift_reg   <= shift_next;
            csum_reg    <= csum_next;
            payload_reg <= payload_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
`ifdef STACKER_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_next     = bit_reg;
        byte_next    = byte_reg;
        shift_next   = shift_reg;
        csum_next    = csum_reg;
        payload_next = payload_reg;

        case (state_reg)
            IDLE: begin
                if (bus.send_i) begin
                    state_next   = START;
                    baud_next    = '0;
                    bit_next     = '0;
                    byte_next    = '0;
                    shift_next   = SYNC_BYTE;
                    csum_next    = SYNC_BYTE;
                    payload_next = {bus.state_i, bus.block_width_i, bus.block_pos_i,
                                    4'b0000, bus.block_height_i, 6'b000000, bus.board_i};
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
`ifdef STACKER_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
`ifdef STACKER_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                if (stop_end) begin
                    state_next = NEXT;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            NEXT: begin
                baud_next = '0;
                if (byte_reg == 4'd15) begin
                    state_next = DONE;
                end else begin
                    state_next = START;
                    byte_next  = byte_reg + 4'd1;
                    if (byte_reg == 4'd14) begin
                        shift_next = csum_reg;
                    end else begin
                        shift_next   = payload_reg[111:104];
                        csum_next    = csum_reg ^ payload_reg[111:104];
                        payload_next = {payload_reg[103:0], 8'h00};
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifdef STACKER_TX_PARITY_EN
        // Parity is taken when a byte is loaded, before shifting destroys it.
        parity_next = parity_reg;
        if (state_reg == IDLE || state_reg == NEXT) begin
            parity_next = ^shift_next;
        end
`endif

        // Line level is registered from the next state so tx_o never glitches.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef STACKER_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE) && (state_next != DONE);
        done_next = (state_next == DONE);
    end

    assign bus.tx_o   = tx_reg;
    assign bus.busy_o = busy_reg;
    assign bus.done_o = done_reg;
endmodule

// File: tb/tb_stacker_state_tx.sv
// Randomized scoreboard bench for stacker_state_tx: a UART line decoder pops
// expected bytes from a reference frame model and checks framing and timing.
module tb_stacker_state_tx;
    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int CPB    = CLK_HZ / BAUD;
`ifdef STACKER_TX_PARITY_EN
    localparam int CH = 11;
`else
    localparam int CH = 10;
`endif
    localparam int FRAME_CYC = 16 * CH * CPB;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    stacker_state_tx_if bus_if();

    stacker_state_tx #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk   (clk),
        .arst_i(arst),
        .bus   (bus_if)
    );

    int         checks   = 0;
    int         errors   = 0;
    int         done_cnt = 0;
    int         char_cnt = 0;
    logic [7:0] exp_q[$];

    logic [1:0]  st_v;
    logic [3:0]  pos_v;
    logic [1:0]  w_v;
    logic [3:0]  h_v;
    logic [89:0] board_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: header, fields, zero-padded board MSB-first, XOR checksum.
    function automatic void push_frame(input logic [1:0] st, input logic [3:0] pos,
                                       input logic [1:0] w, input logic [3:0] h,
                                       input logic [89:0] board);
        logic [95:0] padded;
        logic [7:0]  b[16];
        logic [7:0]  x;
        padded = {6'b0, board};
        b[0] = 8'hA5;
        b[1] = {st, w, pos};
        b[2] = {4'b0, h};
        for (int i = 0; i < 12; i++) b[3+i] = padded[95-8*i -: 8];
        x = 8'h00;
        for (int i = 0; i < 15; i++) x = x ^ b[i];
        b[15] = x;
        for (int i = 0; i < 16; i++) exp_q.push_back(b[i]);
    endfunction

    task automatic set_vals(input logic [1:0] st, input logic [3:0] pos, input logic [1:0] w,
                            input logic [3:0] h, input logic [89:0] board);
        st_v = st; pos_v = pos; w_v = w; h_v = h; board_v = board;
    endtask

    task automatic rand_vals();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        set_vals(2'($urandom_range(0, 2)), 4'($urandom_range(0, 8)), 2'($urandom),
                 4'($urandom_range(0, 9)), r[89:0]);
    endtask

    task automatic drive_vals();
        bus_if.state_i        = st_v;
        bus_if.block_pos_i    = pos_v;
        bus_if.block_width_i  = w_v;
        bus_if.block_height_i = h_v;
        bus_if.board_i        = board_v;
    endtask

    // Issue the current values, confirm acceptance, then scramble the inputs.
    task automatic issue_cur();
        @(negedge clk);
        chk("idle_line_before_accept", 64'(bus_if.tx_o), 64'd1);
        drive_vals();
        bus_if.send_i = 1'b1;
        push_frame(st_v, pos_v, w_v, h_v, board_v);
        @(negedge clk);
        bus_if.send_i = 1'b0;
        chk("accept_busy", 64'(bus_if.busy_o), 64'd1);
        chk("start_bit_latency", 64'(bus_if.tx_o), 64'd0);
        rand_vals();
        drive_vals();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus_if.done_o !== 1'b1 && n < FRAME_CYC + 50) begin
            @(negedge clk);
            n++;
        end
        if (bus_if.done_o !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // Frame monitor: busy run length and done pulse shape.
    int   busy_run  = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (arst) begin
            busy_run  = 0;
            prev_busy = 1'b0;
        end else begin
            if (bus_if.done_o) begin
                done_cnt++;
                chk("done_follows_busy", 64'(prev_busy), 64'd1);
                chk("frame_busy_cycles", 64'(busy_run), 64'(FRAME_CYC));
                chk("busy_low_with_done", 64'(bus_if.busy_o), 64'd0);
                $display("frame %0d complete: busy %0d cycles", done_cnt, busy_run);
            end
            if (bus_if.busy_o) busy_run++;
            else busy_run = 0;
            prev_busy = bus_if.busy_o;
        end
    end

    // Character monitor: decodes tx_o, checks bit stability and pops the scoreboard.
    logic        ch_active = 1'b0;
    int          ch_off    = 0;
    logic [10:0] ch_bits   = '0;
    logic        ch_level  = 1'b1;
    logic        ch_stable = 1'b1;
    logic [7:0]  ch_exp;
    always @(negedge clk) begin
        if (arst) begin
            ch_active = 1'b0;
        end else if (!ch_active) begin
            if (bus_if.tx_o === 1'b0) begin
                ch_active = 1'b1;
                ch_off    = 0;
                ch_bits   = '0;
                ch_level  = 1'b0;
                ch_stable = 1'b1;
            end
        end else begin
            ch_off++;
            if (ch_off % CPB == 0) ch_level = bus_if.tx_o;
            else if (bus_if.tx_o !== ch_level) ch_stable = 1'b0;
            if (ch_off % CPB == CPB / 2) ch_bits[4'(ch_off / CPB)] = bus_if.tx_o;
            if (ch_off == CH * CPB - 1) begin
                ch_active = 1'b0;
                char_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_char", 64'(ch_bits[8:1]), 64'hFFFF);
                end else begin
                    ch_exp = exp_q.pop_front();
                    $display("char %0d: got %02h expected %02h", char_cnt, ch_bits[8:1], ch_exp);
                    chk("char_data", 64'(ch_bits[8:1]), 64'(ch_exp));
                    chk("start_bit", 64'(ch_bits[0]), 64'd0);
                    chk("stop_bit", 64'(ch_bits[CH-1]), 64'd1);
                    chk("bit_timing", 64'(ch_stable), 64'd1);
`ifdef STACKER_TX_PARITY_EN
                    chk("parity_bit", 64'(ch_bits[9]), 64'(^ch_exp));
`endif
                end
            end
        end
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int busy_hi;
        bus_if.send_i = 1'b0;
        set_vals(2'd0, 4'd0, 2'd0, 4'd0, 90'd0);
        drive_vals();
        repeat (3) @(negedge clk);
        chk("reset_tx", 64'(bus_if.tx_o), 64'd1);
        chk("reset_busy", 64'(bus_if.busy_o), 64'd0);
        chk("reset_done", 64'(bus_if.done_o), 64'd0);
        arst = 1'b0;
        @(negedge clk);

        $display("test: basic frame");
        set_vals(2'd0, 4'd3, 2'd3, 4'd5, 90'd0);
        issue_cur();
        wait_done();

        $display("test: board packing");
        set_vals(2'd0, 4'd0, 2'd0, 4'd0, 90'd1);
        issue_cur();
        wait_done();
        set_vals(2'd0, 4'd0, 2'd0, 4'd0, 90'd1 << 89);
        issue_cur();
        wait_done();

        $display("test: send while busy is ignored");
        rand_vals();
        issue_cur();
        repeat (3 * CH * CPB + 7) @(negedge clk);
        d0 = done_cnt;
        rand_vals();
        drive_vals();
        bus_if.send_i = 1'b1;
        @(negedge clk);
        bus_if.send_i = 1'b0;
        chk("busy_during_ignored_send", 64'(bus_if.busy_o), 64'd1);
        wait_done();
        busy_hi = 0;
        repeat (CH * CPB) begin
            @(negedge clk);
            if (bus_if.busy_o) busy_hi++;
        end
        chk("no_second_frame", 64'(busy_hi), 64'd0);
        chk("single_done_pulse", 64'(done_cnt - d0), 64'd1);

        $display("test: send in done cycle ignored, next cycle accepted");
        rand_vals();
        issue_cur();
        wait_done();
        rand_vals();
        drive_vals();
        bus_if.send_i = 1'b1;
        push_frame(st_v, pos_v, w_v, h_v, board_v);
        @(negedge clk);
        chk("send_in_done_ignored", 64'(bus_if.busy_o), 64'd0);
        @(negedge clk);
        bus_if.send_i = 1'b0;
        chk("accept_after_done", 64'(bus_if.busy_o), 64'd1);
        chk("start_after_done", 64'(bus_if.tx_o), 64'd0);
        rand_vals();
        drive_vals();
        wait_done();

        $display("test: random frames");
        for (int i = 0; i < 4; i++) begin
            rand_vals();
            issue_cur();
            wait_done();
        end

        $display("test: reset mid-frame");
        rand_vals();
        issue_cur();
        repeat (7 * CH * CPB + 3 * CPB) @(negedge clk);
        d0 = done_cnt;
        #2 arst = 1'b1;
        #1;
        chk("abort_tx_high", 64'(bus_if.tx_o), 64'd1);
        chk("abort_busy_low", 64'(bus_if.busy_o), 64'd0);
        chk("abort_done_low", 64'(bus_if.done_o), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        arst = 1'b0;
        repeat (2 * CH * CPB) @(negedge clk);
        chk("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
        chk("idle_after_abort", 64'(bus_if.tx_o), 64'd1);
        rand_vals();
        issue_cur();
        wait_done();

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
